// File: rtl/imm_pkg.sv
// imm_pkg: shared selector encoding and parameter checks for imm_gen_pipe (IMM_ZICSR_EN enables IMM_Z)
package imm_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_src_e;
  localparam int INSTR_W = 32;
  function automatic bit xlen_ok(input int xlen);
    return xlen == 32 || xlen == 64;
  endfunction
endpackage

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: combinational RV immediate decode; IMM_Z is legal only when IMM_ZICSR_EN is defined
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [2:0]         i_src,
  output logic [XLEN-1:0]    o_imm,
  output logic               o_illegal
);
  logic        s;
  logic [31:0] w_raw;
  logic        w_unused;
  assign s = i_instr[31];
  assign w_unused = ^i_instr[6:0];
  // Build a 32-bit signed immediate per format; widening to XLEN sign-extends it
  always_comb begin
    w_raw = '0;
    o_illegal = 1'b0;
    case (i_src)
      IMM_I: w_raw = {{20{s}}, i_instr[31:20]};
      IMM_S: w_raw = {{20{s}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: w_raw = {{19{s}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: w_raw = {i_instr[31:12], 12'b0};
      IMM_J: w_raw = {{11{s}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
      IMM_Z: w_raw = {27'b0, i_instr[19:15]};
`else
      IMM_Z: o_illegal = 1'b1;
`endif
      default: o_illegal = 1'b1;
    endcase
    o_imm = o_illegal ? '0 : XLEN'($signed(w_raw));
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry skid buffer (IMM_ZICSR_EN enables IMM_Z)
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_imm_src,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_illegal
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } imm_beat_t;
  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  imm_beat_t r_main, r_skid, w_beat;
  logic      r_main_v, r_skid_v;
  logic      w_acc;
  imm_extract #(.XLEN(XLEN)) u_extract (
    .i_instr   (in_instr),
    .i_src     (in_imm_src),
    .o_imm     (w_beat.imm),
    .o_illegal (w_beat.illegal)
  );
  assign w_beat.tag  = in_tag;
  assign in_ready    = !r_skid_v;
  assign w_acc       = in_valid && in_ready;
  assign out_valid   = r_main_v;
  assign out_imm     = r_main.imm;
  assign out_tag     = r_main.tag;
  assign out_illegal = r_main.illegal;
  // Main refills from skid first (FIFO order), else from input; skid catches beats while main stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_main_v || out_ready) begin
      r_main_v <= r_skid_v || w_acc;
      r_skid_v <= 1'b0;
      if (r_skid_v) r_main <= r_skid;
      else if (w_acc) r_main <= w_beat;
    end else if (w_acc) begin
      r_skid   <= w_beat;
      r_skid_v <= 1'b1;
    end
  end
endmodule
